// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per request, with byte-lane steering and load extension.
// Latency is 2 cycles from req to done (plus wait states); bad requests complete in 1 cycle; a stalled bus times out.
module lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cnt;
  logic        err_q;
  logic [1:0]  code_q;

  logic        illegal;
  logic        misal;
  logic        timed_out;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [3:0]  be;
  logic [31:0] st_dat;

  // Request checks run on the live inputs so the error path completes in one cycle.
  assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2:1] == 2'b10);
  assign misal   = (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == 3'b010 && addr[1:0] != 2'b00);

  assign timed_out = (TIMEOUT != 0) && !mem_ready && (cnt == TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) state_nxt = (illegal || misal) ? RESP : ACCESS;
      end
      ACCESS: begin
        if (mem_ready || timed_out) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_val = mem_rdata;
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    be     = 4'b1111;
    st_dat = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        st_dat = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = 4'b0011 << addr_q[1:0];
        st_dat = {2{wdata_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        st_dat = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt     <= 32'h0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      rdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 32'h0;
            err_q   <= illegal || misal;
            code_q  <= illegal ? 2'b11 : (misal ? 2'b01 : 2'b00);
          end
        end
        ACCESS: begin
          // Ready on the final timeout edge still counts as a successful transfer.
          if (mem_ready) begin
            err_q  <= 1'b0;
            code_q <= 2'b00;
            if (!we_q) rdata <= ld_val;
          end else begin
            cnt <= cnt + 32'd1;
            if (timed_out) begin
              err_q  <= 1'b1;
              code_q <= 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == RESP);
  assign err       = (state == RESP) && err_q;
  assign err_code  = (state == RESP && err_q) ? code_q : 2'b00;
  assign mem_req   = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && we_q;
  assign mem_be    = (state == ACCESS) ? be : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = st_dat;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, request-check errors, timeout, busy and async reset.
module tb_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge; afterwards the DUT is in ACCESS or RESP.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    tick();
    req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
  endtask

  // Complete the access with ready in the current cycle; afterwards the DUT is in RESP.
  task automatic complete(input logic [31:0] rd);
    mem_rdata = rd; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  // Check the RESP cycle, then step back to IDLE.
  task automatic resp(input string tag, input logic e, input logic [1:0] code, input logic [31:0] rd);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".code"}, 32'(err_code), 32'(code));
    chk({tag, ".rdata"}, rdata, rd);
    chk({tag, ".memreq_resp"}, 32'(mem_req), 32'd0);
    tick();
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    reset = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    #3;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", {29'd0, err, err_code}, 32'd0);
    chk("rst.mem_req", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // sw
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    chk("sw.mem_req", 32'(mem_req), 32'd1);
    chk("sw.mem_we", 32'(mem_we), 32'd1);
    chk("sw.mem_addr", mem_addr, 32'h100);
    chk("sw.mem_be", 32'(mem_be), 32'hF);
    chk("sw.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw.busy", 32'(busy), 32'd1);
    chk("sw.done_early", 32'(done), 32'd0);
    complete(32'h0);
    chk("sw.be_off", {27'd0, mem_be, mem_we}, 32'd0);
    resp("sw", 1'b0, 2'b00, 32'h0);

    // loads from 0x80FF_1234
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    chk("lb.mem_addr", mem_addr, 32'h100);
    chk("lb.mem_we", 32'(mem_we), 32'd0);
    complete(32'h80FF_1234);
    resp("lb", 1'b0, 2'b00, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
    complete(32'h80FF_1234);
    resp("lbu", 1'b0, 2'b00, 32'h0000_0080);
    issue(1'b0, 3'b001, 32'h0000_0102, 32'h0);
    complete(32'h80FF_1234);
    resp("lh", 1'b0, 2'b00, 32'hFFFF_80FF);
    issue(1'b0, 3'b101, 32'h0000_0100, 32'h0);
    complete(32'h80FF_1234);
    resp("lhu", 1'b0, 2'b00, 32'h0000_1234);
    issue(1'b0, 3'b000, 32'h0000_0101, 32'h0);
    complete(32'h80FF_1234);
    resp("lb1", 1'b0, 2'b00, 32'h0000_0012);
    issue(1'b0, 3'b010, 32'h0000_0104, 32'h0);
    chk("lw.mem_addr", mem_addr, 32'h104);
    complete(32'h80FF_1234);
    resp("lw", 1'b0, 2'b00, 32'h80FF_1234);

    // sh / sb steering; rdata must not move
    issue(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD);
    chk("sh.mem_addr", mem_addr, 32'h100);
    chk("sh.mem_be", 32'(mem_be), 32'hC);
    chk("sh.mem_wdata", mem_wdata, 32'hABCD_ABCD);
    complete(32'h5555_5555);
    resp("sh", 1'b0, 2'b00, 32'h80FF_1234);
    issue(1'b1, 3'b000, 32'h0000_0101, 32'h0000_005A);
    chk("sb.mem_be", 32'(mem_be), 32'h2);
    chk("sb.mem_wdata", mem_wdata, 32'h5A5A_5A5A);
    complete(32'h0);
    resp("sb", 1'b0, 2'b00, 32'h80FF_1234);

    // request-check errors: done in the cycle right after req, no bus activity
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
    chk("mis.mem_req", 32'(mem_req), 32'd0);
    resp("mis", 1'b1, 2'b01, 32'h80FF_1234);
    issue(1'b0, 3'b001, 32'h0000_0103, 32'h0);
    resp("mish", 1'b1, 2'b01, 32'h80FF_1234);
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h0);
    chk("ill.mem_req", 32'(mem_req), 32'd0);
    resp("ill_sbu", 1'b1, 2'b11, 32'h80FF_1234);
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
    resp("ill_011", 1'b1, 2'b11, 32'h80FF_1234);

    // timeout: mem_req high for exactly 16 cycles
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    chk("to.req_cycles", 32'(n), 32'd16);
    resp("to", 1'b1, 2'b10, 32'h80FF_1234);

    // ready on the 16th cycle wins
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("rw.mem_req16", 32'(mem_req), 32'd1);
    complete(32'h1122_3344);
    resp("rw", 1'b0, 2'b00, 32'h1122_3344);

    // second req while busy is ignored
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h0000_0300; wdata = 32'hFF;
    tick();
    chk("bz.mem_we", 32'(mem_we), 32'd0);
    chk("bz.mem_addr", mem_addr, 32'h100);
    mem_rdata = 32'hCAFE_F00D; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    dones = 0;
    if (done) dones++;
    tick();
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      tick();
    end
    chk("bz.dones", 32'(dones), 32'd1);
    chk("bz.rdata", rdata, 32'hCAFE_F00D);
    chk("bz.busy", 32'(busy), 32'd0);

    // async reset mid-ACCESS
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    chk("ar.mem_req_pre", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar.mem_req", 32'(mem_req), 32'd0);
    chk("ar.busy", 32'(busy), 32'd0);
    chk("ar.rdata", rdata, 32'd0);
    dones = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (done) dones++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
    chk("ar.no_done", 32'(dones), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the core datapath. It takes the ALU result as the effective address, runs one data-memory transaction over a ready-based request bus, and returns byte/halfword/word load data. Stores get byte-lane steering and byte enables. Misaligned accesses, illegal widths and memory timeouts are flagged without hanging the core.

## Interface
- TIMEOUT, 16: max ACCESS cycles waiting for mem_ready before a bus error; 0 disables the timeout.

- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low; forces IDLE and output reset values immediately
- req  in  1  start a transaction; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  000 b, 001 h, 010 w, 100 bu (load only), 101 hu (load only)
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data
- err  out  1  valid with done; 1 = transaction failed
- err_code  out  2  01 misaligned, 10 timeout, 11 illegal funct3/we combination; 00 when err = 0
- mem_req  out  1  bus request, held until accepted or timed out
- mem_we  out  1  bus write enable
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  read data, valid when mem_ready = 1
- mem_ready  in  1  memory accepts/completes the current request

## Operation
- States: IDLE, ACCESS, RESP.
- In IDLE with req = 1, capture addr, funct3, we and wdata on the clock edge, then check the request:
  - Illegal combinations are funct3 ∈ {011, 110, 111}, or we = 1 with funct3 ∈ {100, 101}. These go to RESP with code 11.
  - Misaligned accesses are a halfword with addr[0] = 1, or a word with addr[1:0] ≠ 00. These go to RESP with code 01.
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive mem_req = 1 with mem_we, mem_addr, mem_be and mem_wdata, all stable from the captured registers.
  - mem_ready = 1 at an edge completes the transfer and moves to RESP.
  - For a load, rdata is loaded on that same edge.
- RESP: done = 1 for exactly one cycle, with err/err_code valid. The next state is IDLE.
- Store steering:
  - sb: mem_wdata = {4{wdata[7:0]}}, mem_be = 0001 << addr[1:0].
  - sh: mem_wdata = {2{wdata[15:0]}}, mem_be = 0011 << addr[1:0].
  - sw: mem_wdata = wdata, mem_be = 1111.
- Load extraction:
  - The byte is mem_rdata[8·addr[1:0] +: 8]; the halfword is mem_rdata[16·addr[1] +: 16].
  - b and h are sign-extended; bu and hu are zero-extended; w passes through.
- rdata holds its value until the next successful load. Stores and errored transactions leave it unchanged.
- When mem_req = 0, mem_be = 0000 and mem_we = 0.

## Timing
- Reset values:
  - State is IDLE.
  - busy, done, err and mem_req are 0, err_code is 00, and mem_be is 0000.
  - mem_we is 0, and mem_addr, mem_wdata and rdata are 0.
- Latency, with req sampled at edge E0:
  - ACCESS starts after E0.
  - If mem_ready is high at E1, done is high in the cycle after E1. That is the minimum 2-cycle latency, and each wait cycle adds one.
- Error path: a request that fails the checks (illegal or misaligned) gets done in the cycle after E0. No mem_req is ever asserted for it.
- Timeout:
  - A counter clears on ACCESS entry and increments each ACCESS cycle with mem_ready = 0.
  - At the edge ending the TIMEOUT-th ACCESS cycle, if mem_ready = 0 the FSM goes to RESP with code 10.
  - If mem_ready = 1 on that same edge, ready wins and the transfer succeeds.
  - On a timeout, mem_req is asserted for exactly TIMEOUT cycles.
- req is ignored while busy = 1, including the RESP cycle. There is no queuing.
- reset low mid-ACCESS drops mem_req immediately (asynchronously). No done is issued and rdata returns to 0.

## Test plan
- sw: addr 0x0000_0100, wdata 0xDEAD_BEEF, mem_ready high in the first ACCESS cycle -> mem_addr 0x100, mem_be 1111, mem_wdata 0xDEAD_BEEF, mem_we 1, done 2 cycles after req, err 0.
- lb then lbu: addr 0x103, mem_rdata 0x80FF_1234 -> rdata 0xFFFF_FF80, then 0x0000_0080. lh at addr 0x102 with the same data -> 0xFFFF_80FF.
- sh: addr 0x102, wdata 0x1234_ABCD -> mem_addr 0x100, mem_be 1100, mem_wdata 0xABCD_ABCD. sb at addr 0x101, wdata 0x5A -> mem_be 0010, mem_wdata 0x5A5A_5A5A.
- Request-check errors:
  - lw at addr 0x102 -> mem_req never high; done 1 cycle after req with err 1, code 01; rdata unchanged.
  - Store with funct3 100 -> err 1, code 11.
- Timeout and ready-wins:
  - TIMEOUT = 16 with mem_ready held low -> mem_req high for exactly 16 cycles, then done with err 1, code 10.
  - Repeat with mem_ready rising on the 16th cycle -> success, err 0.
- Reset and busy behaviour:
  - Assert reset low during ACCESS -> mem_req, busy and rdata go to 0 without a clock edge, and no done pulse occurs.
  - A second req pulsed while busy -> ignored, and exactly one done pulse is observed.
